sfi_out_buffer: RTL

- Stage directly downstream of the combinational SFI rewriter.
- Accepts rewritten 64-bit instruction words over a valid/ready handshake, buffers them in a small FIFO and presents them to the consumer (trace/commit sink) over valid/ready.
- Classifies each accepted word as guarded or plain and keeps saturating statistics.
- Decouples the single-cycle rewriter from a stalling consumer.

---
 rtl/sfi_out_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sfi_out_buffer.sv
// Output FIFO behind the SFI rewriter: buffers rewritten words, classifies them and keeps saturating statistics.
// Optional sticky tag-violation flag is built only when SFI_TAG_CHECK_EN is defined.
module sfi_out_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  TAG   = 8'hA2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             in_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [63:0]             out_word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        guarded_cnt,
  output logic [CNT_W-1:0]        plain_cnt,
  input  logic                    viol_clr,
  output logic                    viol
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      6'd40, 6'd41, 6'd42, 6'd43, 6'd44,
      6'd45, 6'd46, 6'd56, 6'd60, 6'd63: is_mem_op = 1'b1;
      default:                           is_mem_op = 1'b0;
    endcase
  endfunction

  logic [63:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] guarded_q, guarded_d;
  logic [CNT_W-1:0] plain_q, plain_d;
  logic             full_s, empty_s, push_s, pop_s, mem_op_s, tagged_s;

  // Full when the wrap bits differ and the index bits match; readiness depends on state only.
  assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign in_ready = ~full_s;
  assign out_valid = ~empty_s;
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = out_ready & ~empty_s;
  assign mem_op_s = is_mem_op(in_word[31:26]);
  assign tagged_s = (in_word[63:56] == TAG);

  assign out_word    = mem_q[rd_ptr_q[AW-1:0]];
  assign level       = level_q;
  assign guarded_cnt = guarded_q;
  assign plain_cnt   = plain_q;

  // Next-state for pointers, occupancy and statistics.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    guarded_d = guarded_q;
    plain_d   = plain_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
    // Untagged memory ops count toward neither statistic.
    if (push_s && mem_op_s && tagged_s && (guarded_q != CNT_MAX)) begin
      guarded_d = guarded_q + CNT_ONE;
    end else begin
      guarded_d = guarded_q;
    end
    if (push_s && !mem_op_s && (plain_q != CNT_MAX)) begin
      plain_d = plain_q + CNT_ONE;
    end else begin
      plain_d = plain_q;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      level_q   <= {PW{1'b0}};
      guarded_q <= {CNT_W{1'b0}};
      plain_q   <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      guarded_q <= guarded_d;
      plain_q   <= plain_d;
    end
  end

  // Word storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_word;
    end
  end

`ifdef SFI_TAG_CHECK_EN
  logic viol_q, viol_d;

  // Sticky violation: a violating push wins over a simultaneous clear.
  always_comb begin
    viol_d = viol_q;
    if (push_s && mem_op_s && !tagged_s) begin
      viol_d = 1'b1;
    end else if (viol_clr) begin
      viol_d = 1'b0;
    end else begin
      viol_d = viol_q;
    end
  end

  // Violation flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_q <= 1'b0;
    end else begin
      viol_q <= viol_d;
    end
  end

  assign viol = viol_q;
`else
  logic unused_viol_clr_s;
  assign unused_viol_clr_s = viol_clr;
  assign viol = 1'b0;
`endif

endmodule
